ccff_readback: RTL

Reads back the FPGA fabric configuration chain from the SoC side.
- Generates prog_clk and shifts the chain one full length.
- Captures each bit leaving ccff_tail and recirculates it into ccff_head, so the fabric configuration is unchanged afterwards.
- Packs the captured bits into WORD_W-bit words, hands them to the RISC-V core over a valid/ready interface, and keeps a running CRC for integrity checks against the bitstream the configuration loader wrote.

---
 rtl/ccff_pkg.sv | 24 ++
 rtl/ccff_crc16_serial.sv | 36 +++
 rtl/ccff_readback.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain readback block.
// Holds the FSM state encoding and the CRC-16-CCITT serial update rule.
package ccff_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_STALL,
        S_FLUSH,
        S_DONE
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One MSB-first serial step: feedback is the outgoing MSB xor the new bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator: one bit per enable, clear reloads the seed.
// Clear has priority over enable so a new readback always starts from the seed.
module ccff_crc16_serial
    import ccff_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ccff_readback.sv
// Reads the fabric configuration chain back through ccff_tail, recirculating each
// bit into ccff_head, packing bits LSB-first into words and accumulating a CRC.
module ccff_readback
    import ccff_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16,
    parameter int DIV    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  chain_len,
    output logic              busy,
    output logic              done,
    output logic              prog_clk,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [15:0]       crc
);

    localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WB_W = $clog2(WORD_W + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
    localparam logic [WB_W-1:0] WB_FULL = WB_W'(WORD_W);

    state_e             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WB_W-1:0]    word_bit_q, word_bit_d;
    logic [WORD_W-1:0]  pack_q, pack_d;
    logic               head_q, head_d;
    logic               prog_clk_q, prog_clk_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WORD_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;

    logic               crc_clr;
    logic               crc_en;
    logic               buf_free;

    assign buf_free = !rd_valid_q || rd_ready;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        len_d      = len_q;
        bit_cnt_d  = bit_cnt_q;
        word_bit_d = word_bit_q;
        pack_d     = pack_q;
        head_d     = head_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q && !rd_ready;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = chain_len;
                    bit_cnt_d  = '0;
                    word_bit_d = '0;
                    pack_d     = '0;
                    phase_d    = '0;
                    crc_clr    = 1'b1;
                    state_d    = (chain_len == '0) ? S_DONE : S_LOW;
                end
            end

            S_LOW: begin
                if (phase_q == PH_LAST) begin
                    head_d     = ccff_tail;
                    pack_d     = pack_q | (WORD_W'(ccff_tail) << word_bit_q);
                    word_bit_d = word_bit_q + WB_W'(1);
                    crc_en     = 1'b1;
                    phase_d    = '0;
                    state_d    = S_HIGH;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            S_HIGH: begin
                if (phase_q == PH_LAST) begin
                    phase_d   = '0;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_d == len_q) begin
                        state_d = S_FLUSH;
                    end else if (word_bit_q == WB_FULL) begin
                        state_d = S_STALL;
                    end else begin
                        state_d = S_LOW;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            S_STALL: begin
                if (buf_free) begin
                    rd_data_d  = pack_q;
                    rd_valid_d = 1'b1;
                    pack_d     = '0;
                    word_bit_d = '0;
                    state_d    = S_LOW;
                end
            end

            // A non-zero word_bit means the final word has not been pushed yet;
            // once pushed, wait for the consumer to take it before finishing.
            S_FLUSH: begin
                if (word_bit_q != '0) begin
                    if (buf_free) begin
                        rd_data_d  = pack_q;
                        rd_valid_d = 1'b1;
                        pack_d     = '0;
                        word_bit_d = '0;
                    end
                end else if (rd_valid_q && rd_ready) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        prog_clk_d = (state_d == S_HIGH);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            len_q      <= '0;
            bit_cnt_q  <= '0;
            word_bit_q <= '0;
            pack_q     <= '0;
            head_q     <= 1'b0;
            prog_clk_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            len_q      <= len_d;
            bit_cnt_q  <= bit_cnt_d;
            word_bit_q <= word_bit_d;
            pack_q     <= pack_d;
            head_q     <= head_d;
            prog_clk_q <= prog_clk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    ccff_crc16_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (ccff_tail),
        .crc    (crc)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign prog_clk  = prog_clk_q;
    assign ccff_head = head_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule
